// File: rtl/page_writer.sv
// Streams bytes into 256-byte page images and programs them through a QSPI
// memory controller with a WREN / PP / RDSR-poll sequence per page.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for start
// S_FILL      | accepting stream bytes into the page image
// S_WREN_ISS  | waiting for controller idle, then launch write-enable
// S_WREN_WAIT | write-enable in flight
// S_PP_ISS    | waiting for controller idle, then launch page-program
// S_PP_WAIT   | page-program in flight
// S_POLL_ISS  | waiting for controller idle, then launch status read
// S_POLL_WAIT | status read in flight, evaluate WIP on completion
// S_NEXT      | page finished: end of stream or refill for the next chunk
// S_DONE      | one-cycle completion pulse
// S_ERR       | controller error or poll timeout, back to idle
module page_writer #(
    parameter int unsigned MAX_POLLS = 65535,
    parameter bit          QUAD      = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [23:0]   base_addr,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic          done,
    output logic          err,
    output logic          active,
    output logic          mc_trigger,
    output logic          mc_quad,
    output logic [7:0]    mc_cmd,
    output logic [2071:0] mc_data_send,
    input  logic [7:0]    mc_readout,
    input  logic          mc_busy,
    input  logic          mc_error
);

    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL,
        S_WREN_ISS,
        S_WREN_WAIT,
        S_PP_ISS,
        S_PP_WAIT,
        S_POLL_ISS,
        S_POLL_WAIT,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [23:0]     addr_q, addr_d;
    logic [8:0]      k_q, k_d;
    logic [2071:0]   data_q, data_d;
    logic            last_q, last_d;
    logic [15:0]     poll_q, poll_d;
    logic [1:0]      hold_q, hold_d;
    logic            trig_q, trig_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            err_q, err_d;

    logic [16:0]     poll_inc;
    logic [11:0]     byte_lsb;
    logic            cmd_cplt;
    logic            unused_readout;

    assign unused_readout = ^mc_readout[7:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            k_q     <= '0;
            data_q  <= '1;
            last_q  <= 1'b0;
            poll_q  <= '0;
            hold_q  <= '0;
            trig_q  <= 1'b0;
            cmd_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            data_q  <= data_d;
            last_q  <= last_d;
            poll_q  <= poll_d;
            hold_q  <= hold_d;
            trig_q  <= trig_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        k_d      = k_q;
        data_d   = data_q;
        last_d   = last_q;
        poll_d   = poll_q;
        hold_d   = hold_q;
        trig_d   = 1'b0;
        cmd_d    = cmd_q;
        err_d    = err_q;

        poll_inc = {1'b0, poll_q} + 17'd1;
        byte_lsb = 12'd2040 - {1'b0, k_q[7:0], 3'b000};
        // hold_q masks mc_busy for the trigger cycle and the one after it
        cmd_cplt = (hold_q == 2'd0) && !mc_busy;
        if (hold_q != 2'd0) begin
            hold_d = hold_q - 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d                = base_addr;
                    k_d                   = '0;
                    data_d                = '1;
                    data_d[2071:2048]     = base_addr;
                    last_d                = 1'b0;
                    poll_d                = '0;
                    err_d                 = 1'b0;
                    state_d               = S_FILL;
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    data_d[byte_lsb +: 8] = in_data;
                    k_d                   = k_q + 9'd1;
                    addr_d                = addr_q + 24'd1;
                    last_d                = in_last;
                    if (in_last || (addr_q[7:0] == 8'hFF) || (k_q == 9'd255)) begin
                        state_d = S_WREN_ISS;
                    end
                end
            end
            S_WREN_ISS: begin
                if (!mc_busy) begin
                    trig_d  = 1'b1;
                    cmd_d   = CMD_WREN;
                    hold_d  = 2'd2;
                    state_d = S_WREN_WAIT;
                end
            end
            S_WREN_WAIT: begin
                if (cmd_cplt) begin
                    if (mc_error) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_PP_ISS;
                    end
                end
            end
            S_PP_ISS: begin
                if (!mc_busy) begin
                    trig_d  = 1'b1;
                    cmd_d   = CMD_PP;
                    hold_d  = 2'd2;
                    state_d = S_PP_WAIT;
                end
            end
            S_PP_WAIT: begin
                if (cmd_cplt) begin
                    poll_d = '0;
                    if (mc_error) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_POLL_ISS;
                    end
                end
            end
            S_POLL_ISS: begin
                if (!mc_busy) begin
                    trig_d  = 1'b1;
                    cmd_d   = CMD_RDSR;
                    hold_d  = 2'd2;
                    state_d = S_POLL_WAIT;
                end
            end
            S_POLL_WAIT: begin
                if (cmd_cplt) begin
                    poll_d = poll_inc[15:0];
                    if (mc_error) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (!mc_readout[0]) begin
                        state_d = S_NEXT;
                    end else if (poll_inc >= 17'(MAX_POLLS)) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_POLL_ISS;
                    end
                end
            end
            S_NEXT: begin
                if (last_q) begin
                    state_d = S_DONE;
                end else begin
                    data_d            = '1;
                    data_d[2071:2048] = addr_q;
                    k_d               = '0;
                    state_d           = S_FILL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready     = (state_q == S_FILL);
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
    assign active       = (state_q != S_IDLE);
    assign mc_trigger   = trig_q;
    assign mc_cmd       = cmd_q;
    assign mc_data_send = data_q;
    assign mc_quad      = QUAD;

endmodule
